mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port of the CPU between two requesters:

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the CPU datapath (fetch and load/store requesters),
// the memory port arbiter and the unified memory model.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          cpu_stall;
  logic          err;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, err
  );

  // Datapath + memory view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, cpu_stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data access (D).
// D wins ties unless it has already taken MAX_D_STREAK grants while I waited.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STREAK_W = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam int unsigned TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] d_streak_q, d_streak_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic                err_q, err_d;
  logic [DW-1:0]       if_rdata_q, if_rdata_d;
  logic [DW-1:0]       d_rdata_q, d_rdata_d;

  logic                any_req;
  logic                pick_d;
  logic                timed_out;

  // Winner selection and end-of-wait conditions
  always_comb begin
    any_req   = bus.d_req | bus.if_req;
    pick_d    = bus.d_req & (~bus.if_req | (d_streak_q != STREAK_W'(MAX_D_STREAK)));
    timed_out = ~bus.mem_ack & (timer_q == TMR_W'(TIMEOUT - 1));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_req) state_d = S_WAIT;
      S_WAIT: if (bus.mem_ack || timed_out) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; strobes default low, held values default to hold
  always_comb begin
    owner_d     = owner_q;
    d_streak_d  = d_streak_q;
    timer_d     = '0;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          mem_en_d = 1'b1;
          if (pick_d) begin
            owner_d     = OWN_D;
            d_gnt_d     = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            // Streak only counts grants that made a pending fetch wait
            if (bus.if_req && (d_streak_q != STREAK_W'(MAX_D_STREAK))) begin
              d_streak_d = d_streak_q + STREAK_W'(1);
            end
          end else begin
            owner_d     = OWN_I;
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            d_streak_d  = '0;
          end
        end
      end

      S_WAIT: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.mem_ack || timed_out) begin
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
          end else begin
            if_rvalid_d = 1'b1;
          end
        end
        if (bus.mem_ack) begin
          if (owner_q == OWN_I) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!mem_we_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end else if (timed_out) begin
          err_d = 1'b1;
          if (owner_q == OWN_I) begin
            if_rdata_d = '0;
          end else begin
            d_rdata_d = '0;
          end
        end
      end

      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_I;
      d_streak_q  <= '0;
      timer_q     <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      owner_q     <= owner_d;
      d_streak_q  <= d_streak_d;
      timer_q     <= timer_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  // Freeze the datapath while either request is still unanswered
  assign bus.cpu_stall = (bus.if_req & ~if_rvalid_q) | (bus.d_req & ~d_rvalid_q);

  a_one_gnt: assert property (@(posedge clock) disable iff (reset) !(if_gnt_q && d_gnt_q));
  a_en_gnt:  assert property (@(posedge clock) disable iff (reset) mem_en_q == (if_gnt_q | d_gnt_q));
  a_one_rv:  assert property (@(posedge clock) disable iff (reset) !(if_rvalid_q && d_rvalid_q));
  a_err_rv:  assert property (@(posedge clock) disable iff (reset) !err_q || (if_rvalid_q | d_rvalid_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a cycle-level reference model predicts
// every grant and completion; a negedge monitor checks them from queues.
module tb_mem_port_arbiter;
  localparam int unsigned AW           = 32;
  localparam int unsigned DW           = 32;
  localparam int unsigned MAX_D_STREAK = 4;
  localparam int unsigned TIMEOUT      = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_D_STREAK(MAX_D_STREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    int          r_cyc;
    bit          own_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    int          cyc;
    bit          own_d;
    logic [31:0] rdata;
    bit          err;
  } rv_t;

  gnt_t gq[$];
  rv_t  rq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Requester and model state (index 0 = fetch, 1 = data)
  bit          r_req[2];
  bit          r_we[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdata[2];
  int          cd[2];
  int          left[2];
  logic [31:0] last_rd[2];
  bit          infl;
  bit          to;
  int          g, a, r, own;
  int          idle_from;
  int          streak;
  logic [31:0] ack_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.if_req  = r_req[0];
    bus.if_addr = r_addr[0];
    bus.d_req   = r_req[1];
    bus.d_we    = r_we[1];
    bus.d_addr  = r_addr[1];
    bus.d_wdata = r_wdata[1];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One randomized traffic phase; returns with the arbiter idle in the current cycle
  task automatic run_random(input int n_i, input int n_d, input int d_gap_max, input int to_pct);
    int  c;
    int  dropped;
    int  budget;
    bit  in_wait;
    budget  = 0;
    left[0] = n_i;
    left[1] = n_d;
    cd[0]   = 0;
    cd[1]   = 0;
    infl    = 1'b0;
    idle_from = cyc;
    while ((left[0] > 0 || left[1] > 0 || r_req[0] || r_req[1] || infl) && budget < 20000) begin
      c = cyc;
      dropped = -1;
      if (infl && c == r) begin
        r_req[own] = 1'b0;
        cd[own] = (own == 1) ? int'($urandom_range(0, 32'(d_gap_max))) : int'($urandom_range(0, 2));
        infl = 1'b0;
        dropped = own;
      end
      for (int x = 0; x < 2; x++) begin
        if (!r_req[x] && x != dropped && left[x] > 0) begin
          if (cd[x] == 0) begin
            r_req[x]   = 1'b1;
            left[x]--;
            r_addr[x]  = 32'($urandom) & 32'hFFFF_FFFC;
            r_we[x]    = (x == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_wdata[x] = 32'($urandom);
          end else begin
            cd[x]--;
          end
        end
      end
      if (!infl && c >= idle_from && (r_req[0] || r_req[1])) begin
        own = (r_req[1] && (!r_req[0] || streak != int'(MAX_D_STREAK))) ? 1 : 0;
        if (own == 0) streak = 0;
        else if (r_req[0] && streak < int'(MAX_D_STREAK)) streak++;
        g  = c + 1;
        to = (int'($urandom_range(0, 99)) < to_pct);
        if (to) begin
          a = -1;
          r = g + int'(TIMEOUT);
          last_rd[own] = '0;
        end else begin
          a = g + int'($urandom_range(0, 3));
          r = a + 1;
          ack_data = 32'($urandom);
          if (!r_we[own]) last_rd[own] = ack_data;
        end
        gq.push_back('{cyc: g, r_cyc: r, own_d: (own == 1), we: r_we[own],
                       addr: r_addr[own], wdata: r_wdata[own]});
        rq.push_back('{cyc: r, own_d: (own == 1), rdata: last_rd[own], err: to});
        infl = 1'b1;
        idle_from = r + 1;
      end
      in_wait = infl && c >= g && c < r;
      if (infl && !to && c == a) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = ack_data;
      end else begin
        // Stray acks outside WAIT must be ignored by the arbiter
        bus.mem_ack   = !in_wait && ($urandom_range(0, 7) == 0);
        bus.mem_rdata = 32'($urandom);
      end
      drive();
      tick();
      budget++;
    end
    bus.mem_ack = 1'b0;
    chk("phase_budget", 64'(budget >= 20000), 64'd0);
  endtask

  // Monitor: compares every DUT grant/completion against the queued predictions
  initial begin
    gnt_t        e;
    rv_t         re;
    bit          g_now, r_now, r_own_d;
    logic [31:0] hold_addr;
    bit          hold_we;
    int          hold_from, hold_to;
    hold_from = 0;
    hold_to   = -1;
    hold_addr = '0;
    hold_we   = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        g_now   = (gq.size() > 0) && (gq[0].cyc == cyc);
        r_now   = (rq.size() > 0) && (rq[0].cyc == cyc);
        r_own_d = r_now ? rq[0].own_d : 1'b0;
        chk("cpu_stall", 64'(bus.cpu_stall),
            64'((bus.if_req & ~(r_now & ~r_own_d)) | (bus.d_req & ~(r_now & r_own_d))));
        if (g_now) begin
          e = gq.pop_front();
          chk("gnt_bits", 64'({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}),
              64'({~e.own_d, e.own_d, 1'b1, e.we}));
          chk("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
          if (e.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
          hold_addr = e.addr;
          hold_we   = e.we;
          hold_from = cyc;
          hold_to   = e.r_cyc;
        end else if (bus.if_gnt || bus.d_gnt || bus.mem_en) begin
          chk("stray_gnt", 64'({bus.if_gnt, bus.d_gnt, bus.mem_en}), 64'd0);
        end else if (cyc > hold_from && cyc < hold_to) begin
          chk("mem_hold", 64'({bus.mem_we, bus.mem_addr}), 64'({hold_we, hold_addr}));
        end
        if (r_now) begin
          re = rq.pop_front();
          chk("rvalid_bits", 64'({bus.if_rvalid, bus.d_rvalid, bus.err}),
              64'({~re.own_d, re.own_d, re.err}));
          chk("rdata", 64'(re.own_d ? bus.d_rdata : bus.if_rdata), 64'(re.rdata));
        end else if (bus.if_rvalid || bus.d_rvalid || bus.err) begin
          chk("stray_rvalid", 64'({bus.if_rvalid, bus.d_rvalid, bus.err}), 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 2; x++) begin
      r_req[x] = 1'b0; r_we[x] = 1'b0; r_addr[x] = '0; r_wdata[x] = '0; last_rd[x] = '0;
    end
    streak = 0;
    reset = 1'b1;
    r_req[0] = 1'b1;
    drive();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    repeat (3) tick();

    // Reset holds everything at zero while cpu_stall still follows if_req
    chk("rst_strobes", 64'({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                            bus.if_rvalid, bus.d_rvalid, bus.err}), 64'd0);
    chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
    chk("rst_mem", {bus.mem_addr, bus.mem_wdata}, 64'd0);
    chk("rst_stall", 64'(bus.cpu_stall), 64'd1);

    r_req[0] = 1'b0;
    drive();
    bus.mem_ack = 1'b0;
    reset = 1'b0;
    tick();

    mon_en = 1'b1;
    run_random(10, 40, 0, 0);    // dense data traffic: streak limit must let fetches through
    run_random(40, 40, 3, 8);    // mixed traffic with occasional timeouts
    run_random(1, 1, 2, 100);    // forced timeouts on both owners
    run_random(4, 4, 1, 0);      // normal service after timeouts
    repeat (2) tick();
    mon_en = 1'b0;
    chk("gq_drained", 64'(gq.size()), 64'd0);
    chk("rq_drained", 64'(rq.size()), 64'd0);

    // Reset in WAIT with a simultaneous ack and a late ack: both discarded
    r_req[1] = 1'b1; r_we[1] = 1'b0; r_addr[1] = 32'h40; r_wdata[1] = 32'h0;
    drive();
    tick();
    chk("dir_d_gnt", 64'({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}), 64'b0110);
    chk("dir_d_addr", 64'(bus.mem_addr), 64'h40);
    reset = 1'b1;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'hCAFE_0001;
    r_req[1] = 1'b0;
    drive();
    tick();
    chk("dir_rst_strobes", 64'({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                                bus.if_rvalid, bus.d_rvalid, bus.err, bus.cpu_stall}), 64'd0);
    chk("dir_rst_data", {bus.if_rdata, bus.d_rdata}, 64'd0);
    chk("dir_rst_addr", 64'(bus.mem_addr), 64'd0);
    reset = 1'b0;
    bus.mem_rdata = 32'hCAFE_0002;
    tick();
    chk("dir_late_ack", 64'({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.err}), 64'd0);
    chk("dir_late_data", {bus.if_rdata, bus.d_rdata}, 64'd0);

    // Fresh fetch with ack in the mem_en cycle
    bus.mem_ack = 1'b0;
    r_req[0] = 1'b1;
    r_addr[0] = 32'h0000_0004;
    drive();
    tick();
    chk("dir_i_gnt", 64'({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we}), 64'b1010);
    chk("dir_i_addr", 64'(bus.mem_addr), 64'h4);
    chk("dir_i_stall", 64'(bus.cpu_stall), 64'd1);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h2008_0005;
    tick();
    chk("dir_i_rvalid", 64'({bus.if_rvalid, bus.d_rvalid, bus.err, bus.cpu_stall}), 64'b1000);
    chk("dir_i_rdata", 64'(bus.if_rdata), 64'h2008_0005);
    bus.mem_ack = 1'b0;
    r_req[0] = 1'b0;
    drive();
    tick();
    chk("dir_idle", 64'({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
